// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - switch, counter and status signals between counter_ctrl and the board/counter side
interface counter_ctrl_if;
    logic [1:0] switches;
    logic [3:0] counter_out;
    logic       cnt_rst;
    logic       cnt_en;
    logic [3:0] leds;
    logic [1:0] state;

    modport master (
        input  switches,
        input  counter_out,
        output cnt_rst,
        output cnt_en,
        output leds,
        output state
    );

    modport slave (
        output switches,
        output counter_out,
        input  cnt_rst,
        input  cnt_en,
        input  leds,
        input  state
    );
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - switch sync/debounce, run/pause/clear FSM, prescaled enable and LED register
module counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int TICK_DIV        = 125000000
) (
    input  logic          clk,
    input  logic          rst,
    counter_ctrl_if.master bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DLIM = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TLIM = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        CLEAR = 2'b11
    } state_t;

    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         db_q, db_d;
    logic [1:0]         db_dly_q, db_dly_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;
    state_t             state_q, state_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               cnt_rst_q, cnt_rst_d;
    logic               cnt_en_q, cnt_en_d;
    logic [3:0]         leds_q, leds_d;

    always_comb begin
        sync1_d  = bus.switches;
        sync2_d  = sync1_q;
        db_d     = db_q;
        dcnt_d   = dcnt_q;
        // Any matching cycle restarts the count, so only stable levels get through.
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DLIM) begin
                db_d[i]   = sync2_q[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
        db_dly_d = db_q;
        press_d  = db_q & ~db_dly_q;

        state_d = state_q;
        case (state_q)
            CLEAR:   state_d = IDLE;
            default: begin
                if (press_q[1])      state_d = CLEAR;
                else if (press_q[0]) state_d = (state_q == RUN) ? PAUSE : RUN;
            end
        endcase
        cnt_rst_d = (state_d == CLEAR);

        // Strobe decision uses the current state, so a terminal count on the exit edge still fires.
        tcnt_d   = '0;
        cnt_en_d = 1'b0;
        case (state_q)
            RUN: begin
                if (tcnt_q == TLIM) begin
                    tcnt_d   = '0;
                    cnt_en_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            PAUSE:   tcnt_d = tcnt_q;
            default: tcnt_d = '0;
        endcase

        leds_d = bus.counter_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_dly_q  <= '0;
            press_q   <= '0;
            dcnt_q    <= '0;
            state_q   <= CLEAR;
            tcnt_q    <= '0;
            cnt_rst_q <= 1'b1;
            cnt_en_q  <= 1'b0;
            leds_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_dly_q  <= db_dly_d;
            press_q   <= press_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            cnt_rst_q <= cnt_rst_d;
            cnt_en_q  <= cnt_en_d;
            leds_q    <= leds_d;
        end
    end

    assign bus.cnt_rst = cnt_rst_q;
    assign bus.cnt_en  = cnt_en_q;
    assign bus.leds    = leds_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed self-checking bench for counter_ctrl
module tb_counter_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   en_seen;
    int   overlap;
    logic [3:0] cnt_model;

    counter_ctrl_if bus();

    counter_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)                    cnt_model <= 4'd0;
        else if (bus.cnt_rst === 1'b1) cnt_model <= 4'd0;
        else if (bus.cnt_en === 1'b1)  cnt_model <= cnt_model + 4'd1;
    end
    assign bus.counter_out = cnt_model;

    always @(negedge clk) begin
        if (bus.cnt_rst === 1'b1 && bus.cnt_en === 1'b1) overlap++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        en_seen      = 0;
        overlap      = 0;
        rst          = 1'b0;
        bus.switches = 2'b00;

        // 1: reset and release
        #1 rst = 1'b1;
        #1;
        chk("rst_state", 8'(bus.state), 8'h3);
        chk("rst_cnt_rst", 8'(bus.cnt_rst), 8'h1);
        chk("rst_cnt_en", 8'(bus.cnt_en), 8'h0);
        chk("rst_leds", 8'(bus.leds), 8'h0);
        repeat (3) tick();
        rst = 1'b0;
        chk("rel_cnt_rst_held", 8'(bus.cnt_rst), 8'h1);
        tick();
        chk("rel_cnt_rst_low", 8'(bus.cnt_rst), 8'h0);
        chk("rel_state_idle", 8'(bus.state), 8'h0);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.cnt_en === 1'b1) en_seen++;
        end
        chk("idle_no_en", 8'(en_seen), 8'h0);

        // 3: glitch shorter than the debounce window
        bus.switches = 2'b01;
        repeat (3) tick();
        bus.switches = 2'b00;
        repeat (10) tick();
        chk("glitch_state", 8'(bus.state), 8'h0);
        chk("glitch_dcnt", 8'(dut.dcnt_q[0]), 8'h0);

        // 2: clean step on run switch
        bus.switches = 2'b01;
        repeat (7) tick();
        chk("step_state_pre", 8'(bus.state), 8'h0);
        tick();
        chk("step_state_run", 8'(bus.state), 8'h1);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("run_en_%0d", k), 8'(bus.cnt_en), (k % 5 == 0) ? 8'h1 : 8'h0);
            if (k == 7)  chk("leds_1", 8'(bus.leds), 8'h1);
            if (k == 12) chk("leds_2", 8'(bus.leds), 8'h2);
            if (k == 17) chk("leds_3", 8'(bus.leds), 8'h3);
        end

        // 5: both switches together while running
        bus.switches = 2'b00;
        repeat (8) tick();
        bus.switches = 2'b11;
        repeat (7) tick();
        chk("both_press", 8'(dut.press_q), 8'h3);
        chk("both_state_run", 8'(bus.state), 8'h1);
        tick();
        chk("both_state_clear", 8'(bus.state), 8'h3);
        chk("both_cnt_rst", 8'(bus.cnt_rst), 8'h1);
        tick();
        chk("both_state_idle", 8'(bus.state), 8'h0);
        chk("both_cnt_rst_low", 8'(bus.cnt_rst), 8'h0);
        chk("both_tcnt", 8'(dut.tcnt_q), 8'h0);
        bus.switches = 2'b00;
        repeat (10) tick();
        chk("release_idle", 8'(bus.state), 8'h0);

        // 4: run 17 edges, pause, resume
        bus.switches = 2'b01;
        repeat (8) tick();
        chk("p_state_run", 8'(bus.state), 8'h1);
        bus.switches = 2'b00;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 9) bus.switches = 2'b01;
            chk($sformatf("p_en_%0d", k), 8'(bus.cnt_en), (k % 5 == 0) ? 8'h1 : 8'h0);
        end
        chk("p_state_pause", 8'(bus.state), 8'h2);
        bus.switches = 2'b00;
        en_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.cnt_en === 1'b1) en_seen++;
        end
        bus.switches = 2'b01;
        repeat (7) tick();
        if (bus.cnt_en === 1'b1) en_seen++;
        chk("pause_no_en", 8'(en_seen), 8'h0);
        chk("pause_tcnt_held", 8'(dut.tcnt_q), 8'h2);
        chk("pause_state", 8'(bus.state), 8'h2);
        tick();
        chk("resume_state", 8'(bus.state), 8'h1);
        tick();
        chk("resume_en_1", 8'(bus.cnt_en), 8'h0);
        tick();
        chk("resume_en_2", 8'(bus.cnt_en), 8'h0);
        tick();
        chk("resume_en_3", 8'(bus.cnt_en), 8'h1);

        // 6: asynchronous reset while strobing
        repeat (5) tick();
        chk("pre_rst_en", 8'(bus.cnt_en), 8'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_en", 8'(bus.cnt_en), 8'h0);
        chk("async_cnt_rst", 8'(bus.cnt_rst), 8'h1);
        chk("async_leds", 8'(bus.leds), 8'h0);
        chk("async_state", 8'(bus.state), 8'h3);
        chk("no_rst_en_overlap", 8'(overlap), 8'h0);
        tick();
        rst = 1'b0;
        bus.switches = 2'b00;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
